// File: rtl/uart_pkg.sv
// Shared UART types and defaults, used by the TX serializer and the future RX deserializer.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    localparam int UART_DEFAULT_DATA_BITS = 8;
    localparam int UART_DEFAULT_DIV_WIDTH = 16;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// TX fifo read port: the serializer is the master (it issues pops), the fifo is the slave.
interface uart_tx_serializer_if #(
    parameter int DATA_BITS = 8
);

    logic                 rd_en;
    logic                 empty;
    logic [DATA_BITS-1:0] dout;

    modport master (output rd_en, input empty, input dout);
    modport slave  (input rd_en, output empty, output dout);

endinterface

// File: rtl/uart_baud_timer.sv
// Bit-period down-counter: load starts a period of load_val_i+1 cycles, bit_end_o flags its last cycle.
module uart_baud_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             bit_end_o,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] cnt_q;
    logic             run_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
            run_q <= 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - WIDTH'(1);
            end
        end
    end

    assign bit_end_o = run_q && (cnt_q == '0);
    assign count_o   = cnt_q;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: pops bytes from the TX fifo and sends them LSB first as start/data/stop frames.
//  state | meaning
//  IDLE  | line high, pops when enabled and fifo has data
//  LOAD  | registered-output fifo: capture dout one cycle after the pop
//  START | start bit (low)
//  DATA  | payload bits, LSB first
//  STOP  | stop bit(s) (high), done in the very last cycle
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DEFAULT_DATA_BITS,
    parameter int STOP_BITS = 1,
    parameter int DIV_WIDTH = UART_DEFAULT_DIV_WIDTH,
    parameter bit FIFO_FWFT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] clk_div_i,
    uart_tx_serializer_if.master fifo_if,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);

    uart_tx_state_t       state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 pop;
    logic                 capture;
    logic                 bit_end;
    logic                 last_data;
    logic                 last_stop;
    logic                 final_end;
    logic                 enter_final;
    logic                 done_set;
    logic                 tmr_load;
    logic [DIV_WIDTH-1:0] tmr_val;
    logic [DIV_WIDTH-1:0] tmr_cnt;

    assign pop           = (state_q == IDLE) && en_i && !fifo_if.empty;
    assign fifo_if.rd_en = pop;
    assign capture       = FIFO_FWFT ? pop : (state_q == LOAD);

    assign last_data = (bit_cnt_q == CNT_W'(DATA_BITS - 1));
    assign last_stop = (bit_cnt_q == CNT_W'(STOP_BITS - 1));
    assign final_end = (state_q == STOP) && last_stop && bit_end;

    // The first bit period takes clk_div_i directly since div_q is only written on the same edge.
    assign tmr_load = capture || (bit_end && !final_end);
    assign tmr_val  = capture ? clk_div_i : div_q;

    // done is registered, so it is set one cycle ahead of the final stop-bit cycle.
    assign enter_final = bit_end &&
                         (((state_q == DATA) && last_data && (STOP_BITS == 1)) ||
                          ((state_q == STOP) && !last_stop));
    assign done_set    = (enter_final && (div_q == '0)) ||
                         ((state_q == STOP) && last_stop && !bit_end && (tmr_cnt == DIV_WIDTH'(1)));

    uart_baud_timer #(
        .WIDTH (DIV_WIDTH)
    ) u_baud_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .bit_end_o  (bit_end),
        .count_o    (tmr_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            div_q     <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= done_set;
            if (capture) begin
                shift_q <= fifo_if.dout;
                div_q   <= clk_div_i;
            end
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q <= FIFO_FWFT ? START : LOAD;
                        busy_q  <= 1'b1;
                        if (FIFO_FWFT) begin
                            tx_q <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    state_q <= START;
                    tx_q    <= 1'b0;
                end
                START: begin
                    if (bit_end) begin
                        state_q   <= DATA;
                        bit_cnt_q <= '0;
                        tx_q      <= shift_q[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (last_data) begin
                            state_q   <= STOP;
                            bit_cnt_q <= '0;
                            tx_q      <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (last_stop) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three DUTs (registered fifo, FWFT fifo, 7-bit/2-stop) fed by 4-deep fifo models.
module tb_uart_tx_serializer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        en   [3] = '{default: 1'b0};
    logic [15:0] cdiv [3] = '{default: 16'd0};
    logic        tx   [3];
    logic        busy [3];
    logic        done [3];
    logic        frd  [3];

    int vectors     = 0;
    int miscompares = 0;

    uart_tx_serializer_if #(.DATA_BITS(8)) if0 ();
    uart_tx_serializer_if #(.DATA_BITS(8)) if1 ();
    uart_tx_serializer_if #(.DATA_BITS(7)) if2 ();

    uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1), .DIV_WIDTH(16), .FIFO_FWFT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en_i(en[0]), .clk_div_i(cdiv[0]), .fifo_if(if0),
        .tx_o(tx[0]), .busy_o(busy[0]), .done_o(done[0]));
    uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1), .DIV_WIDTH(16), .FIFO_FWFT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en_i(en[1]), .clk_div_i(cdiv[1]), .fifo_if(if1),
        .tx_o(tx[1]), .busy_o(busy[1]), .done_o(done[1]));
    uart_tx_serializer #(.DATA_BITS(7), .STOP_BITS(2), .DIV_WIDTH(16), .FIFO_FWFT(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .en_i(en[2]), .clk_div_i(cdiv[2]), .fifo_if(if2),
        .tx_o(tx[2]), .busy_o(busy[2]), .done_o(done[2]));

    // Upstream fifo models, WIDTH=8 DEPTH=4 each
    logic [7:0] fmem  [3][4];
    int         fcnt  [3] = '{0, 0, 0};
    int         frp   [3] = '{0, 0, 0};
    int         fwp   [3] = '{0, 0, 0};
    int         pops  [3] = '{0, 0, 0};
    logic [7:0] fdreg [3] = '{default: 8'h00};
    logic       fpush [3] = '{default: 1'b0};
    logic [7:0] fdin  [3] = '{default: 8'h00};

    assign frd[0]    = if0.rd_en;
    assign frd[1]    = if1.rd_en;
    assign frd[2]    = if2.rd_en;
    assign if0.empty = (fcnt[0] == 0);
    assign if1.empty = (fcnt[1] == 0);
    assign if2.empty = (fcnt[2] == 0);
    assign if0.dout  = fdreg[0];
    assign if1.dout  = fmem[1][frp[1]];
    assign if2.dout  = fdreg[2][6:0];

    always @(posedge clk) begin
        for (int c = 0; c < 3; c++) begin
            automatic bit do_pop  = frd[c] && (fcnt[c] > 0);
            automatic bit do_push = fpush[c] && (fcnt[c] < 4);
            if (do_pop) begin
                fdreg[c] <= fmem[c][frp[c]];
                frp[c]   <= (frp[c] + 1) % 4;
            end
            if (do_push) begin
                fmem[c][fwp[c]] <= fdin[c];
                fwp[c]          <= (fwp[c] + 1) % 4;
            end
            fcnt[c] <= fcnt[c] + int'(do_push) - int'(do_pop);
            if (frd[c]) pops[c] <= pops[c] + 1;
        end
    end

    task automatic push(input int c, input logic [7:0] b);
        @(negedge clk);
        fpush[c] = 1'b1;
        fdin[c]  = b;
        @(negedge clk);
        fpush[c] = 1'b0;
    endtask

    // Reference: a frame is start(0), nbits data LSB first, nstop ones, each bit div+1 cycles,
    // done only in the final cycle, then an idle cycle with busy low.
    task automatic check_frame(input int c, input logic [7:0] data, input int nbits, input int nstop,
                               input int div, input string tag, output int gap);
        int          waited  = 0;
        int          total   = 1 + nbits + nstop;
        logic [11:0] frame   = '1;
        logic        bits_ok = 1'b1;
        logic        done_ok = 1'b1;
        int          bad_bit = -1;
        logic        bad_tx  = 1'b0;
        logic        bad_bsy = 1'b0;
        int          done_n  = 0;
        frame[0] = 1'b0;
        for (int i = 0; i < nbits; i++) frame[i+1] = data[i];
        while (tx[c] !== 1'b0 && waited < 600) begin
            @(negedge clk);
            waited++;
        end
        gap = waited;
        vectors++;
        if (tx[c] !== 1'b0) begin
            miscompares++;
            $display("FAIL %s start: tx=%b after %0d cycles, required 0", tag, tx[c], waited);
            return;
        end
        for (int b = 0; b < total; b++) begin
            for (int k = 0; k <= div; k++) begin
                if ((tx[c] !== frame[b] || busy[c] !== 1'b1) && bits_ok) begin
                    bits_ok = 1'b0;
                    bad_bit = b;
                    bad_tx  = tx[c];
                    bad_bsy = busy[c];
                end
                if (done[c] === 1'b1) done_n++;
                if (done[c] !== ((b == total - 1) && (k == div))) done_ok = 1'b0;
                @(negedge clk);
            end
        end
        vectors++;
        if (!bits_ok) begin
            miscompares++;
            $display("FAIL %s line: bit %0d tx=%b busy=%b, required tx=%b busy=1",
                     tag, bad_bit, bad_tx, bad_bsy, frame[bad_bit]);
        end
        vectors++;
        if (!done_ok) begin
            miscompares++;
            $display("FAIL %s done: %0d high cycles (misplaced), required 1 in last stop cycle", tag, done_n);
        end
        vectors++;
        if (busy[c] !== 1'b0 || tx[c] !== 1'b1 || done[c] !== 1'b0) begin
            miscompares++;
            $display("FAIL %s end: busy=%b tx=%b done=%b, required 0 1 0", tag, busy[c], tx[c], done[c]);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (tx[c] !== 1'b1 || busy[c] !== 1'b0 || done[c] !== 1'b0 || frd[c] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset[%0d]: tx=%b busy=%b done=%b rd_en=%b, required 1 0 0 0",
                         c, tx[c], busy[c], done[c], frd[c]);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame();
        for (int c = 0; c < 2; c++) begin
            int p0;
            int lat = 0;
            int gap;
            cdiv[c] = 16'd3;
            en[c]   = 1'b1;
            p0      = pops[c];
            push(c, 8'hA5);
            vectors++;
            if (frd[c] !== 1'b1) begin
                miscompares++;
                $display("FAIL single[%0d] rd_en: got %b, required 1", c, frd[c]);
            end
            while (tx[c] !== 1'b0 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            vectors++;
            if (lat != 2 - c) begin
                miscompares++;
                $display("FAIL single[%0d] latency: got %0d cycles, required %0d", c, lat, 2 - c);
            end
            check_frame(c, 8'hA5, 8, 1, 3, "single", gap);
            repeat (4) @(negedge clk);
            vectors++;
            if (pops[c] - p0 != 1) begin
                miscompares++;
                $display("FAIL single[%0d] pops: got %0d, required 1", c, pops[c] - p0);
            end
            en[c] = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'h3C};
        for (int c = 0; c < 2; c++) begin
            int p0;
            int gap;
            cdiv[c] = 16'd0;
            for (int i = 0; i < 3; i++) push(c, bytes[i]);
            p0 = pops[c];
            @(negedge clk);
            en[c] = 1'b1;
            for (int i = 0; i < 3; i++) begin
                check_frame(c, bytes[i], 8, 1, 0, "b2b", gap);
                if (i > 0) begin
                    vectors++;
                    if (gap != 2 - c) begin
                        miscompares++;
                        $display("FAIL b2b[%0d] gap: got %0d idle cycles, required %0d", c, gap, 2 - c);
                    end
                end
            end
            repeat (5) @(negedge clk);
            vectors++;
            if (pops[c] - p0 != 3) begin
                miscompares++;
                $display("FAIL b2b[%0d] pops: got %0d, required 3", c, pops[c] - p0);
            end
            en[c] = 1'b0;
        end
    endtask

    task automatic test_idle_empty();
        logic ok [3] = '{default: 1'b1};
        for (int c = 0; c < 3; c++) en[c] = 1'b1;
        repeat (100) begin
            @(negedge clk);
            for (int c = 0; c < 3; c++)
                if (frd[c] !== 1'b0 || tx[c] !== 1'b1 || busy[c] !== 1'b0) ok[c] = 1'b0;
        end
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (!ok[c]) begin
                miscompares++;
                $display("FAIL idle[%0d]: activity with empty fifo, required rd_en=0 tx=1 busy=0", c);
            end
            en[c] = 1'b0;
        end
    endtask

    task automatic test_midframe_cfg();
        int   p0;
        int   gap;
        logic quiet = 1'b1;
        cdiv[0] = 16'd3;
        push(0, 8'h55);
        push(0, 8'h66);
        p0 = pops[0];
        @(negedge clk);
        en[0] = 1'b1;
        fork
            check_frame(0, 8'h55, 8, 1, 3, "cfg_old", gap);
            begin
                repeat (20) @(negedge clk);
                cdiv[0] = 16'd7;
                en[0]   = 1'b0;
            end
        join
        repeat (30) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0) quiet = 1'b0;
        end
        vectors++;
        if (!quiet || pops[0] - p0 != 1) begin
            miscompares++;
            $display("FAIL cfg hold: pops=%0d quiet=%b, required pops=1 quiet=1", pops[0] - p0, quiet);
        end
        en[0] = 1'b1;
        check_frame(0, 8'h66, 8, 1, 7, "cfg_new", gap);
        en[0] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        int w = 0;
        int gap;
        cdiv[0] = 16'd3;
        push(0, 8'hC3);
        push(0, 8'h3C);
        @(negedge clk);
        en[0] = 1'b1;
        while (tx[0] !== 1'b0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        repeat (16) @(negedge clk);
        vectors++;
        if (busy[0] !== 1'b1 || tx[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_pre: busy=%b tx=%b, required 1 0 (data bit 3 of 0xC3)", busy[0], tx[0]);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        en[0] = 1'b0;
        #1;
        vectors++;
        if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async: tx=%b busy=%b done=%b, required 1 0 0", tx[0], busy[0], done[0]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        en[0] = 1'b1;
        check_frame(0, 8'h3C, 8, 1, 3, "rst_next", gap);
        en[0] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_short_frame();
        int gap;
        cdiv[2] = 16'd1;
        push(2, 8'h41);
        push(2, 8'hC1);
        @(negedge clk);
        en[2] = 1'b1;
        check_frame(2, 8'h41, 7, 2, 1, "b7s2_41", gap);
        check_frame(2, 8'h41, 7, 2, 1, "b7s2_c1", gap);
        vectors++;
        if (gap != 2) begin
            miscompares++;
            $display("FAIL b7s2 gap: got %0d, required 2", gap);
        end
        en[2] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 3; r++) begin
                logic [7:0] q [$];
                int n   = $urandom_range(1, 4);
                int div = $urandom_range(0, 4);
                int nb  = (c == 2) ? 7 : 8;
                int ns  = (c == 2) ? 2 : 1;
                int p0;
                int gap;
                cdiv[c] = 16'(div);
                for (int i = 0; i < n; i++) begin
                    logic [7:0] b = 8'($urandom);
                    q.push_back(b);
                    push(c, b);
                end
                p0 = pops[c];
                @(negedge clk);
                en[c] = 1'b1;
                for (int i = 0; i < n; i++) begin
                    check_frame(c, q[i], nb, ns, div, "rand", gap);
                    if (i > 0) begin
                        vectors++;
                        if (gap != ((c == 1) ? 1 : 2)) begin
                            miscompares++;
                            $display("FAIL rand[%0d] gap: got %0d, required %0d", c, gap, (c == 1) ? 1 : 2);
                        end
                    end
                end
                en[c] = 1'b0;
                repeat (3) @(negedge clk);
                vectors++;
                if (pops[c] - p0 != n) begin
                    miscompares++;
                    $display("FAIL rand[%0d] pops: got %0d, required %0d", c, pops[c] - p0, n);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_idle_empty();
        test_midframe_cfg();
        test_reset_midframe();
        test_short_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
